decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 175 +++++++++++++++++
 tb/tb_decode_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: in-order queue of fetched MIPS32 instructions with combinational decode of the head entry.
// Define DECODE_QUEUE_CP0_EN to decode COP0 MTC0/MFC0/ERET; otherwise every COP0 op is reported invalid.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [11:0]              out_ctrl,
  output logic                     out_invalid,
  output logic                     out_break,
  output logic                     out_syscall,
  output logic                     out_eret,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         invalid_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  // {regwrite, regdst[1:0], alusrc, branch, memwrite, memtoreg, jump, hilo_write, jbral, jr, cp0_write}
  localparam logic [11:0] C_RTYPE = 12'hA00;
  localparam logic [11:0] C_HILO  = 12'h008;
  localparam logic [11:0] C_JR    = 12'h002;
  localparam logic [11:0] C_JALR  = 12'hA06;
  localparam logic [11:0] C_IMM   = 12'h900;
  localparam logic [11:0] C_BR    = 12'h080;
  localparam logic [11:0] C_BRAL  = 12'hC84;
  localparam logic [11:0] C_LOAD  = 12'h920;
  localparam logic [11:0] C_STORE = 12'h140;
  localparam logic [11:0] C_J     = 12'h010;
  localparam logic [11:0] C_JAL   = 12'hC14;
`ifdef DECODE_QUEUE_CP0_EN
  localparam logic [11:0] C_MTC0  = 12'h001;
  localparam logic [11:0] C_MFC0  = 12'h800;
`endif

  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [OW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [31:0]    head_inst;
  logic [31:0]    head_pc;
  logic [11:0]    ctrl;
  logic           dec_invalid;
  logic           dec_break;
  logic           dec_syscall;
`ifdef DECODE_QUEUE_CP0_EN
  logic           dec_eret;
`endif

  assign full      = (count == OW'(DEPTH));
  assign empty     = (count == '0);
  // rst gates in_ready directly so it drops the instant reset asserts
  assign in_ready  = !rst && !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign occupancy = count;
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      invalid_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
      if (pop && dec_invalid && (invalid_cnt != '1))
        invalid_cnt <= invalid_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl        = '0;
    dec_invalid = 1'b0;
    dec_break   = 1'b0;
    dec_syscall = 1'b0;
`ifdef DECODE_QUEUE_CP0_EN
    dec_eret    = 1'b0;
`endif
    case (head_inst[31:26])
      6'b000000: begin
        case (head_inst[5:0])
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011:                         ctrl = C_RTYPE;
          6'b010001, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011:   ctrl = C_HILO;
          6'b001000:                                    ctrl = C_JR;
          6'b001001:                                    ctrl = C_JALR;
          6'b001100:                                    dec_syscall = 1'b1;
          6'b001101:                                    dec_break   = 1'b1;
          default:                                      dec_invalid = 1'b1;
        endcase
      end
      6'b000001: begin
        case (head_inst[20:16])
          5'b00000, 5'b00001: ctrl = C_BR;
          5'b10000, 5'b10001: ctrl = C_BRAL;
          default:            dec_invalid = 1'b1;
        endcase
      end
      6'b000010:                                        ctrl = C_J;
      6'b000011:                                        ctrl = C_JAL;
      6'b000100, 6'b000101, 6'b000110, 6'b000111:       ctrl = C_BR;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111:       ctrl = C_IMM;
`ifdef DECODE_QUEUE_CP0_EN
      6'b010000: begin
        case (head_inst[25:21])
          5'b00100: ctrl = C_MTC0;
          5'b00000: ctrl = C_MFC0;
          5'b10000: begin
            if (head_inst[5:0] == 6'b011000) dec_eret = 1'b1;
            else                             dec_invalid = 1'b1;
          end
          default:  dec_invalid = 1'b1;
        endcase
      end
`endif
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: ctrl = C_LOAD;
      6'b101000, 6'b101001, 6'b101011:                       ctrl = C_STORE;
      default:                                               dec_invalid = 1'b1;
    endcase
  end

  assign out_pc      = out_valid ? head_pc   : '0;
  assign out_inst    = out_valid ? head_inst : '0;
  assign out_ctrl    = out_valid ? ctrl      : '0;
  assign out_invalid = out_valid && dec_invalid;
  assign out_break   = out_valid && dec_break;
  assign out_syscall = out_valid && dec_syscall;
`ifdef DECODE_QUEUE_CP0_EN
  assign out_eret    = out_valid && dec_eret;
`else
  assign out_eret    = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table, directed corner sequences, and random traffic vs a queue model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [31:0]       in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [11:0]       out_ctrl;
  logic              out_invalid;
  logic              out_break;
  logic              out_syscall;
  logic              out_eret;
  logic [OW-1:0]     occupancy;
  logic [CNT_W-1:0]  invalid_cnt;

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_ctrl(out_ctrl),
    .out_invalid(out_invalid), .out_break(out_break), .out_syscall(out_syscall),
    .out_eret(out_eret), .occupancy(occupancy), .invalid_cnt(invalid_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode rules as mask/match records, queue contents as a SV queue.
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [11:0] ctrl;
    logic [3:0]  flags;   // {invalid, break, syscall, eret}
  } rule_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  rule_t rules[$];
  ent_t  q[$];
  int    m_inv = 0;

  function automatic void add_rule(input logic [31:0] mask, input logic [31:0] match,
                                   input logic [11:0] ctrl, input logic [3:0] flags);
    rule_t r;
    r.mask = mask; r.match = match; r.ctrl = ctrl; r.flags = flags;
    rules.push_back(r);
  endfunction

  task automatic build_rules();
    int rt_f[18] = '{0, 2, 3, 4, 6, 7, 16, 18, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    int hl_f[6]  = '{17, 19, 24, 25, 26, 27};
    int ld_op[5] = '{32, 33, 35, 36, 37};
    int st_op[3] = '{40, 41, 43};
    foreach (rt_f[i]) add_rule(32'hFC00003F, 32'(rt_f[i]), 12'hA00, 4'b0000);
    foreach (hl_f[i]) add_rule(32'hFC00003F, 32'(hl_f[i]), 12'h008, 4'b0000);
    add_rule(32'hFC00003F, 32'd8,  12'h002, 4'b0000);
    add_rule(32'hFC00003F, 32'd9,  12'hA06, 4'b0000);
    add_rule(32'hFC00003F, 32'd12, 12'h000, 4'b0010);
    add_rule(32'hFC00003F, 32'd13, 12'h000, 4'b0100);
    add_rule(32'hFC1F0000, (32'd1 << 26) | (32'd0  << 16), 12'h080, 4'b0000);
    add_rule(32'hFC1F0000, (32'd1 << 26) | (32'd1  << 16), 12'h080, 4'b0000);
    add_rule(32'hFC1F0000, (32'd1 << 26) | (32'd16 << 16), 12'hC84, 4'b0000);
    add_rule(32'hFC1F0000, (32'd1 << 26) | (32'd17 << 16), 12'hC84, 4'b0000);
    add_rule(32'hFC000000, 32'd2 << 26, 12'h010, 4'b0000);
    add_rule(32'hFC000000, 32'd3 << 26, 12'hC14, 4'b0000);
    for (int op = 4; op <= 7; op++)  add_rule(32'hFC000000, 32'(op) << 26, 12'h080, 4'b0000);
    for (int op = 8; op <= 15; op++) add_rule(32'hFC000000, 32'(op) << 26, 12'h900, 4'b0000);
    foreach (ld_op[i]) add_rule(32'hFC000000, 32'(ld_op[i]) << 26, 12'h920, 4'b0000);
    foreach (st_op[i]) add_rule(32'hFC000000, 32'(st_op[i]) << 26, 12'h140, 4'b0000);
`ifdef DECODE_QUEUE_CP0_EN
    add_rule(32'hFFE00000, 32'h40800000, 12'h001, 4'b0000);
    add_rule(32'hFFE00000, 32'h40000000, 12'h800, 4'b0000);
    add_rule(32'hFFE0003F, 32'h42000018, 12'h000, 4'b0001);
`endif
  endtask

  function automatic void ref_dec(input logic [31:0] inst, output logic [11:0] c, output logic [3:0] f);
    c = '0;
    f = 4'b1000;
    foreach (rules[i]) begin
      if ((inst & rules[i].mask) == rules[i].match) begin
        c = rules[i].ctrl;
        f = rules[i].flags;
        break;
      end
    end
  endfunction

  // One clock: drive inputs, compare at negedge against the model, advance the model at posedge.
  task automatic cyc(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                     input logic orr, input logic fl);
    logic e_rdy, e_vld;
    logic [11:0] ec;
    logic [3:0] ef;
    ent_t e;
    in_valid = iv; in_inst = inst; in_pc = pc; out_ready = orr; flush = fl;
    @(negedge clk);
    e_rdy = !fl && (q.size() < DEPTH);
    e_vld = (q.size() > 0);
    ec = '0;
    ef = '0;
    check("in_ready", in_ready, e_rdy);
    check("out_valid", out_valid, e_vld);
    check("occupancy", occupancy, q.size());
    check("invalid_cnt", invalid_cnt, m_inv);
    if (e_vld) begin
      ref_dec(q[0].inst, ec, ef);
      check("head", {out_pc, out_inst}, {q[0].pc, q[0].inst});
      check("decode", {out_ctrl, out_invalid, out_break, out_syscall, out_eret}, {ec, ef});
    end else begin
      check("decode_idle", {out_ctrl, out_invalid, out_break, out_syscall, out_eret}, 64'd0);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (e_vld && orr) begin
        if (ef[3] && m_inv < (1 << CNT_W) - 1) m_inv++;
        void'(q.pop_front());
      end
      if (iv && e_rdy) begin
        e.pc = pc; e.inst = inst;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_inst = '0; in_pc = '0;
    @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 0);
    check("rst_invalid_cnt", invalid_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_inv = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    int pool[16] = '{0, 0, 0, 1, 2, 3, 4, 5, 8, 9, 15, 16, 35, 43, 32, 63};
    int fn[8]    = '{0, 8, 9, 12, 13, 24, 33, 42};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'(pool[$urandom_range(0, 15)]);
    if (w[31:26] == 6'd0 && $urandom_range(0, 1) == 1) w[5:0] = 6'(fn[$urandom_range(0, 7)]);
    if (w[31:26] == 6'd16 && $urandom_range(0, 1) == 1) w = 32'h42000018;
    return w;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [11:0] ctrl;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{32'h00851021, 12'hA00, 4'b0000};  // ADDU
    tbl[1]  = '{32'h00000000, 12'hA00, 4'b0000};  // SLL (nop)
    tbl[2]  = '{32'h00850018, 12'h008, 4'b0000};  // MULT
    tbl[3]  = '{32'h03E00008, 12'h002, 4'b0000};  // JR
    tbl[4]  = '{32'h0080F809, 12'hA06, 4'b0000};  // JALR
    tbl[5]  = '{32'h0000000C, 12'h000, 4'b0010};  // SYSCALL
    tbl[6]  = '{32'h0000000D, 12'h000, 4'b0100};  // BREAK
    tbl[7]  = '{32'h24420001, 12'h900, 4'b0000};  // ADDIU
    tbl[8]  = '{32'h10000003, 12'h080, 4'b0000};  // BEQ
    tbl[9]  = '{32'h04110004, 12'hC84, 4'b0000};  // BGEZAL
    tbl[10] = '{32'h8C820004, 12'h920, 4'b0000};  // LW
    tbl[11] = '{32'hAC820004, 12'h140, 4'b0000};  // SW
    tbl[12] = '{32'h08000010, 12'h010, 4'b0000};  // J
    tbl[13] = '{32'h0C000010, 12'hC14, 4'b0000};  // JAL
    tbl[14] = '{32'h04020000, 12'h000, 4'b1000};  // REGIMM rt=2
`ifdef DECODE_QUEUE_CP0_EN
    tbl[15] = '{32'h42000018, 12'h000, 4'b0001};  // ERET
    tbl[16] = '{32'h40026000, 12'h800, 4'b0000};  // MFC0
`else
    tbl[15] = '{32'h42000018, 12'h000, 4'b1000};
    tbl[16] = '{32'h40026000, 12'h000, 4'b1000};
`endif

    build_rules();
    do_reset();

    // First push appears the following cycle
    cyc(1'b1, 32'h00851021, 32'hBFC00000, 1'b0, 1'b0);
    #2;
    check("first_valid", out_valid, 1'b1);
    check("first_ctrl", out_ctrl, 12'hA00);
    check("first_pc", out_pc, 32'hBFC00000);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].inst, 32'(i * 4), 1'b0, 1'b0);
      #2;
      check($sformatf("tbl%0d", i), {out_ctrl, out_invalid, out_break, out_syscall, out_eret},
            {tbl[i].ctrl, tbl[i].flags});
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Fill to DEPTH, overflow attempt, then wrap the pointers
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'h24420000 + 32'(k), 32'h1000 + 32'(k * 4), 1'b0, 1'b0);
      if (k == 3) begin
        #2;
        check("full_occ", occupancy, 4);
        check("full_ready", in_ready, 1'b0);
      end
    end
    cyc(1'b1, 32'h2442FFFF, 32'h2000, 1'b1, 1'b0);
    cyc(1'b1, 32'h24420010, 32'h1010, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with 3 entries while pushing and popping
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h8C820000 + 32'(k), 32'h3000 + 32'(k * 4), 1'b0, 1'b0);
    cyc(1'b1, 32'hAC820000, 32'h4000, 1'b1, 1'b1);
    #2;
    check("flush_occ", occupancy, 0);
    check("flush_valid", out_valid, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Invalid counter and its saturation at CNT_W=2
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'hFC000000 + 32'(k), 32'h5000 + 32'(k * 4), 1'b0, 1'b0);
    cyc(1'b1, 32'h8C820004, 32'h500C, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #2;
    check("inv_cnt3", invalid_cnt, 2'd3);
    check("lw_ctrl", out_ctrl, 12'h920);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'hFC000003, 32'h6000, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #2;
    check("inv_cnt_sat", invalid_cnt, 2'd3);

    // Random traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 1) == 1,
          $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-cycle with two entries queued
    do_reset();
    cyc(1'b1, 32'h00851021, 32'h7000, 1'b0, 1'b0);
    cyc(1'b1, 32'hFC000000, 32'h7004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_occ", occupancy, 0);
    check("async_valid", out_valid, 1'b0);
    check("async_ready", in_ready, 1'b0);
    check("async_decode", {out_ctrl, out_invalid, out_break, out_syscall, out_eret}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_inv = 0;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
